// File: rtl/rv32_mem_arb_pkg.sv
// Shared types for the rv32 data memory arbiter: FSM state, read-response owner
// and wait counter width.
package rv32_mem_arb_pkg;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic {CORE_PRIO, AUX_PRIO} arb_state_t;
  typedef enum logic {OWNER_CORE, OWNER_AUX} arb_owner_t;
endpackage

// File: rtl/rv32_arb_age_counter.sv
// Counts consecutive denied aux cycles while the core has priority and flags
// promotion when the count reaches AUX_MAX_WAIT; clear marks the end of an aux wait.
module rv32_arb_age_counter
  import rv32_mem_arb_pkg::*;
#(
  parameter int AUX_MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic core_prio_i,
  input  logic aux_req_i,
  input  logic aux_gnt_i,
  output logic promote_o,
  output logic clear_o
);

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;

  always_comb begin
    wait_cnt_inc = wait_cnt_q + WAIT_CNT_W'(1);
    clear_o      = ~aux_req_i | aux_gnt_i;
    promote_o    = core_prio_i & aux_req_i & ~aux_gnt_i &
                   (wait_cnt_inc == WAIT_CNT_W'(AUX_MAX_WAIT));
    wait_cnt_d   = wait_cnt_q;
    // The count only means something in CORE_PRIO; leaving it starts from zero.
    if (clear_o || !core_prio_i || promote_o) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/rv32_data_memory_arbiter.sv
// Shares one single-port data memory between the core and an aux master with aging
// priority and per-owner read routing. Optional counters: RV32_MEM_ARB_PERF_EN.
module rv32_data_memory_arbiter
  import rv32_mem_arb_pkg::*;
#(
  parameter int AUX_MAX_WAIT = 4,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  core_req_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [3:0]            core_we_i,
  input  logic [31:0]           core_wdata_i,
  output logic                  core_gnt_o,
  output logic                  core_stall_o,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  input  logic                  aux_req_i,
  input  logic [ADDR_WIDTH-1:0] aux_addr_i,
  input  logic [3:0]            aux_we_i,
  input  logic [31:0]           aux_wdata_i,
  output logic                  aux_gnt_o,
  output logic                  aux_rvalid_o,
  output logic [31:0]           aux_rdata_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
`ifdef RV32_MEM_ARB_PERF_EN
  ,
  output logic [31:0]           conflict_cnt_o,
  output logic [15:0]           aux_starve_cnt_o
`endif
);

  arb_state_t state_q, state_d;
  arb_owner_t rsp_owner_q, rsp_owner_d;
  logic       rsp_pending_q, rsp_pending_d;
  logic       core_win, aux_win, promote, clear;

  rv32_arb_age_counter #(
    .AUX_MAX_WAIT(AUX_MAX_WAIT)
  ) u_age (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .core_prio_i(state_q == CORE_PRIO),
    .aux_req_i  (aux_req_i),
    .aux_gnt_i  (aux_win),
    .promote_o  (promote),
    .clear_o    (clear)
  );

  always_comb begin
    core_win = ~rst_i & core_req_i & (~aux_req_i | (state_q == CORE_PRIO));
    aux_win  = ~rst_i & aux_req_i & (~core_req_i | (state_q == AUX_PRIO));

    core_gnt_o   = core_win;
    aux_gnt_o    = aux_win;
    core_stall_o = core_req_i & ~core_win;

    mem_en_o    = core_win | aux_win;
    mem_we_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (core_win) begin
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (aux_win) begin
      mem_we_o    = aux_we_i;
      mem_addr_o  = aux_addr_i;
      mem_wdata_o = aux_wdata_i;
    end

    rsp_pending_d = (core_win & (core_we_i == 4'b0000)) | (aux_win & (aux_we_i == 4'b0000));
    rsp_owner_d   = aux_win ? OWNER_AUX : OWNER_CORE;

    state_d = state_q;
    case (state_q)
      CORE_PRIO: if (promote) state_d = AUX_PRIO;
      AUX_PRIO:  if (clear)   state_d = CORE_PRIO;
      default:                state_d = CORE_PRIO;
    endcase

    // Memory read data is one cycle behind the access that owns it.
    core_rvalid_o = ~rst_i & rsp_pending_q & (rsp_owner_q == OWNER_CORE);
    aux_rvalid_o  = ~rst_i & rsp_pending_q & (rsp_owner_q == OWNER_AUX);
    core_rdata_o  = mem_rdata_i;
    aux_rdata_o   = mem_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= CORE_PRIO;
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= OWNER_CORE;
    end else begin
      state_q       <= state_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
    end
  end

`ifdef RV32_MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] aux_starve_cnt_q, aux_starve_cnt_d;

  always_comb begin
    conflict_cnt_d   = conflict_cnt_q;
    aux_starve_cnt_d = aux_starve_cnt_q;
    if (core_req_i && aux_req_i && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
    if ((state_q == CORE_PRIO) && (state_d == AUX_PRIO) && (aux_starve_cnt_q != '1)) begin
      aux_starve_cnt_d = aux_starve_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_q   <= '0;
      aux_starve_cnt_q <= '0;
    end else begin
      conflict_cnt_q   <= conflict_cnt_d;
      aux_starve_cnt_q <= aux_starve_cnt_d;
    end
  end

  assign conflict_cnt_o   = conflict_cnt_q;
  assign aux_starve_cnt_o = aux_starve_cnt_q;
`endif

endmodule

// File: tb/tb_rv32_data_memory_arbiter.sv
// Randomized and directed bench for rv32_data_memory_arbiter against a
// denial-counting reference model.
module tb_rv32_data_memory_arbiter;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i, aux_req_i;
  logic [31:0] core_addr_i, aux_addr_i;
  logic [3:0]  core_we_i, aux_we_i;
  logic [31:0] core_wdata_i, aux_wdata_i;
  logic        core_gnt_o, core_stall_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        aux_gnt_o, aux_rvalid_o;
  logic [31:0] aux_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;
  int denied = 0;
  int prev_owner = -1;
  bit dut_gc, dut_ga;

  always #5 clk = ~clk;

  rv32_data_memory_arbiter #(.AUX_MAX_WAIT(MAXW), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_stall_o(core_stall_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .aux_req_i(aux_req_i), .aux_addr_i(aux_addr_i), .aux_we_i(aux_we_i),
    .aux_wdata_i(aux_wdata_i), .aux_gnt_o(aux_gnt_o), .aux_rvalid_o(aux_rvalid_o),
    .aux_rdata_o(aux_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational and response outputs, advance model.
  task automatic cyc(input bit rst,
                     input bit cr, input logic [31:0] ca, input logic [3:0] cwe, input logic [31:0] cwd,
                     input bit ar, input logic [31:0] aa, input logic [3:0] awe, input logic [31:0] awd,
                     input logic [31:0] rd);
    bit gc, ga;
    logic [3:0]  ewe;
    logic [31:0] eaddr, ewd;
    @(negedge clk);
    rst_i = rst;
    core_req_i = cr; core_addr_i = ca; core_we_i = cwe; core_wdata_i = cwd;
    aux_req_i = ar;  aux_addr_i = aa;  aux_we_i = awe;  aux_wdata_i = awd;
    mem_rdata_i = rd;
    #2;
    gc = !rst && cr && (!ar || denied < MAXW);
    ga = !rst && ar && (!cr || denied >= MAXW);
    ewe = 4'h0; eaddr = 32'h0; ewd = 32'h0;
    if (gc) begin ewe = cwe; eaddr = ca; ewd = cwd; end
    else if (ga) begin ewe = awe; eaddr = aa; ewd = awd; end

    check_eq("grants", {core_gnt_o, aux_gnt_o}, {gc, ga});
    check_eq("stall", core_stall_o, cr && !gc);
    check_eq("mem_en", mem_en_o, gc || ga);
    check_eq("mem_we", mem_we_o, ewe);
    if (!rst) begin
      check_eq("mem_addr", mem_addr_o, eaddr);
      check_eq("mem_wdata", mem_wdata_o, ewd);
    end
    check_eq("rvalid", {core_rvalid_o, aux_rvalid_o},
             {!rst && prev_owner == 0, !rst && prev_owner == 1});
    if (!rst && prev_owner == 0) check_eq("core_rdata", core_rdata_o, rd);
    if (!rst && prev_owner == 1) check_eq("aux_rdata", aux_rdata_o, rd);
    dut_gc = core_gnt_o;
    dut_ga = aux_gnt_o;

    if (rst) begin
      denied = 0;
      prev_owner = -1;
    end else begin
      prev_owner = (gc && cwe == 4'h0) ? 0 : ((ga && awe == 4'h0) ? 1 : -1);
      denied = (ar && !ga) ? denied + 1 : 0;
    end
  endtask

  task automatic idle(input bit rst, input logic [31:0] rd);
    cyc(rst, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, rd);
  endtask

  // Core writes continuously while aux reads; returns the conflict cycle aux wins in.
  task automatic aux_latency(output int lat);
    lat = 0;
    for (int i = 0; i < 10 && lat == 0; i++) begin
      cyc(0, 1, 32'h200 + 32'(i * 4), 4'hF, 32'h1100 + 32'(i), 1, 32'h300, 4'h0, 32'h0, $urandom);
      if (dut_ga) lat = i + 1;
    end
  endtask

  initial begin
    int lat;
    bit cr, ar, rst;
    logic [31:0] ca, cwd, aa, awd;
    logic [3:0]  cwe, awe;

    // Reset state.
    idle(1, 32'h0);
    cyc(1, 1, 32'h40, 4'h0, 32'h0, 1, 32'h80, 4'h0, 32'h0, 32'h0);
    idle(0, 32'h0);

    // Core-only read, response next cycle.
    cyc(0, 1, 32'h100, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    idle(0, 32'hDEADBEEF);

    // Aging: aux wins on the fifth conflict cycle, then priority returns to core.
    aux_latency(lat);
    check_eq("aux_lat", lat, 5);
    cyc(0, 1, 32'h220, 4'hF, 32'h5, 1, 32'h304, 4'h0, 32'h0, 32'hA5A5A5A5);
    check_eq("core_prio_again", dut_gc, 1);
    idle(0, 32'h0);

    // Alternating owners with back-to-back reads.
    cyc(0, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h20, 4'h0, 32'h0, 32'h11111111);
    idle(0, 32'h22222222);

    // Withdrawn aux request clears aging.
    cyc(0, 1, 32'h30, 4'h3, 32'h7, 1, 32'h40, 4'h0, 32'h0, 32'h0);
    cyc(0, 1, 32'h34, 4'h3, 32'h7, 1, 32'h40, 4'h0, 32'h0, 32'h0);
    cyc(0, 1, 32'h38, 4'h3, 32'h7, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    aux_latency(lat);
    check_eq("aux_lat_after_drop", lat, 5);
    idle(0, 32'h0);

    // Reset with an aux read in flight.
    cyc(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h50, 4'h0, 32'h0, 32'h0);
    idle(1, 32'h33333333);
    idle(0, 32'h44444444);
    cyc(0, 1, 32'h60, 4'h0, 32'h0, 1, 32'h64, 4'h0, 32'h0, 32'h0);
    check_eq("core_prio_after_rst", dut_gc, 1);

    // Randomized traffic with held requests, withdrawals and occasional reset.
    cr = 0; ar = 0; ca = 0; cwd = 0; aa = 0; awd = 0; cwe = 0; awe = 0;
    dut_gc = 0; dut_ga = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cr && !dut_gc) begin
        if ($urandom_range(15) == 0) cr = 0;
      end else begin
        cr  = ($urandom_range(3) != 0);
        ca  = $urandom;
        cwe = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
        cwd = $urandom;
      end
      if (ar && !dut_ga) begin
        if ($urandom_range(15) == 0) ar = 0;
      end else begin
        ar  = ($urandom_range(1) != 0);
        aa  = $urandom;
        awe = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
        awd = $urandom;
      end
      rst = ($urandom_range(49) == 0);
      cyc(rst, cr, ca, cwe, cwd, ar, aa, awe, awd, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv32_data_memory_arbiter.md
Name: rv32_data_memory_arbiter

Overview:
- Shares one single-port synchronous data memory (1-cycle read latency, 4-bit byte write enable) between two requesters.
- Requester 0 is the core memory stage. Requester 1 is an auxiliary master (debug/DMA).
- Arbitrates each cycle and generates a stall to the core when it loses.
- Routes each registered read response back to the requester that issued it.
- Ages auxiliary requests so the core cannot starve them.

Parameters:
- AUX_MAX_WAIT, 4: consecutive denied aux cycles before aux gets priority; legal range 1..15.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- core_req_i  input  1  core memory-stage access request.
- core_addr_i  input  ADDR_WIDTH  core byte address.
- core_we_i  input  4  core byte write enable; 0 means read.
- core_wdata_i  input  32  core write data, already lane-aligned.
- core_gnt_o  output  1  core access accepted this cycle.
- core_stall_o  output  1  core_req_i & ~core_gnt_o.
- core_rvalid_o  output  1  core read data valid.
- core_rdata_o  output  32  core read data.
- aux_req_i  input  1  aux access request.
- aux_addr_i  input  ADDR_WIDTH  aux byte address.
- aux_we_i  input  4  aux byte write enable; 0 means read.
- aux_wdata_i  input  32  aux write data.
- aux_gnt_o  output  1  aux access accepted this cycle.
- aux_rvalid_o  output  1  aux read data valid.
- aux_rdata_o  output  32  aux read data.
- mem_en_o  output  1  memory access enable.
- mem_we_o  output  4  memory byte write enable.
- mem_addr_o  output  ADDR_WIDTH  memory address.
- mem_wdata_o  output  32  memory write data.
- mem_rdata_i  input  32  memory read data, valid the cycle after a read.

Behaviour:
- One clock (clk_i). Reset rst_i is synchronous and active-high.
- While rst_i = 1:
  - Both grants, mem_en_o, mem_we_o and both rvalids are forced to 0.
  - The state register resets to CORE_PRIO, wait_cnt to 0, rsp_pending to 0.
- Grants are combinational from the requests and the current state:
  - In CORE_PRIO the core wins a conflict.
  - In AUX_PRIO aux wins a conflict.
  - A lone request is always granted.
- The memory bus is muxed from the winner's addr/we/wdata. mem_en_o = winner exists. With no request, mem_we_o = 0 and addr/wdata hold don't-care (drive 0).
- Read response routing:
  - A granted read (we == 0) sets rsp_pending = 1 and rsp_owner = winner at the next edge.
  - In the following cycle the owner's rvalid_o = 1 and its rdata_o = mem_rdata_i. The other requester sees rvalid 0.
  - rdata outputs are driven from mem_rdata_i unconditionally and are valid only with rvalid.
- A granted write produces no response.
- Back-to-back reads from alternating owners are legal: the owner is re-registered every cycle.
- FSM states: CORE_PRIO, AUX_PRIO.
  - CORE_PRIO: wait_cnt increments when aux_req_i & ~aux_gnt_o. It clears when aux is granted or aux_req_i = 0.
  - CORE_PRIO -> AUX_PRIO when the incremented value equals AUX_MAX_WAIT.
  - AUX_PRIO: aux is granted on its next request cycle. AUX_PRIO -> CORE_PRIO when aux is granted, or aux_req_i drops. wait_cnt clears on that transition.
  - Worst-case aux latency is AUX_MAX_WAIT + 1 cycles from first denied request.
- Requesters must hold req/addr/we/wdata stable until granted. A request withdrawn before grant is legal and clears aging.
- Reset asserted with a read in flight: rsp_pending clears and no rvalid is emitted afterward.

Optional Feature:
- Macro RV32_MEM_ARB_PERF_EN.
- Defined: adds outputs conflict_cnt_o [31:0] and aux_starve_cnt_o [15:0].
  - conflict_cnt_o increments each cycle both requests are present.
  - aux_starve_cnt_o increments on each CORE_PRIO->AUX_PRIO transition.
  - Both saturate and reset to 0.
- Undefined: ports and counters absent; arbitration unchanged.

Decomposition:
- Package rv32_mem_arb_pkg holds:
  - enum arb_state_t {CORE_PRIO, AUX_PRIO};
  - enum arb_owner_t {OWNER_CORE, OWNER_AUX};
  - localparam WAIT_CNT_W = 4.
- One sub-module is natural: rv32_arb_age_counter, the wait counter plus threshold compare, emitting promote/clear.

Test Plan:
- Core-only read addr 0x100, mem returns 0xDEADBEEF -> core_gnt_o same cycle, core_rvalid_o=1 next cycle with 0xDEADBEEF, aux_rvalid_o=0.
- Simultaneous core write (we=4'b1111) and aux read, AUX_MAX_WAIT=4, core requesting continuously -> aux denied 4 cycles, granted on 5th, core_stall_o=1 that cycle only, FSM returns CORE_PRIO.
- Alternating grants: core read cycle N, aux read cycle N+1 -> core_rvalid_o at N+1, aux_rvalid_o at N+2, data not swapped.
- Aux denied 2 cycles then drops request -> wait_cnt clears to 0; re-request needs full 4 denials before promotion.
- Aux read granted, rst_i asserted next cycle -> no rvalid on either port, all grants 0 during reset, state CORE_PRIO after release.
- With RV32_MEM_ARB_PERF_EN: 10 conflict cycles -> conflict_cnt_o=10, aux_starve_cnt_o=2 with AUX_MAX_WAIT=4.
